// File: rtl/intersection_pkg.sv
// intersection_pkg: shared fault codes, lamp one-hot check and default sizing
package intersection_pkg;
    localparam int DEF_DEPTH = 15;
    localparam int DEF_DEPART_GAP = 2;
    localparam logic [1:0] FC_NONHOT = 2'b01;
    localparam logic [1:0] FC_CONFLICT = 2'b10;
    function automatic logic one_hot3(input logic r, input logic y, input logic g);
        return ({r, y, g} == 3'b100) || ({r, y, g} == 3'b010) || ({r, y, g} == 3'b001);
    endfunction
endpackage

// File: rtl/approach_lane.sv
// approach_lane: one direction's car queue with paced green departures and right turn on red
module approach_lane
    import intersection_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = 4,
    parameter int DEPART_GAP = DEF_DEPART_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arrive_i,
    input  logic             right_turn_i,
    input  logic             red_i,
    input  logic             yellow_i,
    input  logic             green_i,
    input  logic             fault_i,
    output logic             sensor_o,
    output logic [CNT_W-1:0] count_o,
    output logic             depart_o,
    output logic             drop_o
);
    logic [CNT_W-1:0] count_q, count_d, gap_q, gap_d;
    logic depart_q, drop_q, depart_d, drop_d, dep_green, dep_rtor, full;
    always_comb begin
        dep_green = green_i && !yellow_i && count_q != '0 && gap_q == '0 && !fault_i;
        dep_rtor  = red_i && !yellow_i && right_turn_i && count_q != '0 && !fault_i;
        depart_d  = dep_green || dep_rtor;
        full      = count_q == CNT_W'(DEPTH);
        drop_d    = arrive_i && !depart_d && full;
        count_d   = (arrive_i && !depart_d && !full) ? count_q + 1'b1 :
                    (!arrive_i && depart_d) ? count_q - 1'b1 : count_q;
        // timer is held clear off green so the first green cycle can depart at once
        gap_d     = !green_i ? '0 :
                    dep_green ? CNT_W'(DEPART_GAP - 1) :
                    (gap_q != '0) ? gap_q - 1'b1 : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            gap_q    <= '0;
            depart_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            gap_q    <= gap_d;
            depart_q <= depart_d;
            drop_q   <= drop_d;
        end
    end
    assign count_o  = count_q;
    assign sensor_o = count_q != '0;
    assign depart_o = depart_q;
    assign drop_o   = drop_q;
endmodule

// File: rtl/intersection_model.sv
// intersection_model: two approach lanes plus a sticky lamp-conflict monitor
module intersection_model
    import intersection_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = 4,
    parameter int DEPART_GAP = DEF_DEPART_GAP
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             NS_arrive,
    input  logic             EW_arrive,
    input  logic             NS_right_turn,
    input  logic             EW_right_turn,
    input  logic             NS_Red,
    input  logic             NS_Yellow,
    input  logic             NS_Green,
    input  logic             EW_Red,
    input  logic             EW_Yellow,
    input  logic             EW_Green,
    output logic             NS_sensor,
    output logic             EW_sensor,
    output logic [CNT_W-1:0] NS_count,
    output logic [CNT_W-1:0] EW_count,
    output logic             NS_depart,
    output logic             EW_depart,
    output logic             NS_drop,
    output logic             EW_drop,
    output logic             Fault,
    output logic [1:0]       Fault_code
);
    logic [1:0] fc_q, fc_d;
    logic blank_q, nonhot, conflict;
    approach_lane #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DEPART_GAP(DEPART_GAP)) u_ns (
        .clk(Clock), .rst(Reset), .arrive_i(NS_arrive), .right_turn_i(NS_right_turn),
        .red_i(NS_Red), .yellow_i(NS_Yellow), .green_i(NS_Green), .fault_i(Fault),
        .sensor_o(NS_sensor), .count_o(NS_count), .depart_o(NS_depart), .drop_o(NS_drop)
    );
    approach_lane #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DEPART_GAP(DEPART_GAP)) u_ew (
        .clk(Clock), .rst(Reset), .arrive_i(EW_arrive), .right_turn_i(EW_right_turn),
        .red_i(EW_Red), .yellow_i(EW_Yellow), .green_i(EW_Green), .fault_i(Fault),
        .sensor_o(EW_sensor), .count_o(EW_count), .depart_o(EW_depart), .drop_o(EW_drop)
    );
    always_comb begin
        nonhot   = !one_hot3(NS_Red, NS_Yellow, NS_Green) || !one_hot3(EW_Red, EW_Yellow, EW_Green);
        conflict = !NS_Red && !EW_Red;
        // the blank cycle tolerates whatever the controller shows before it initialises
        fc_d     = blank_q ? fc_q : fc_q | ({2{nonhot}} & FC_NONHOT) | ({2{conflict}} & FC_CONFLICT);
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fc_q    <= 2'b00;
            blank_q <= 1'b1;
        end else begin
            fc_q    <= fc_d;
            blank_q <= 1'b0;
        end
    end
    assign Fault_code = fc_q;
    assign Fault      = |fc_q;
endmodule
